// File: rtl/fpdiv_ctrl.sv
// Control sequencer for the single-multiplier Goldschmidt divide datapath.
// Moore FSM with registered outputs plus a numerator-refinement counter.
module fpdiv_ctrl #(
  parameter int ITERS = 3,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [1:0]       sel_muxa,
  output logic [1:0]       sel_muxb,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  if (ITERS < 1 || ITERS > 7) begin : g_bad_iters
    $error("fpdiv_ctrl: ITERS must be in 1..7");
  end
  if ((1 << CNT_W) <= ITERS) begin : g_bad_cnt_w
    $error("fpdiv_ctrl: CNT_W too narrow for ITERS");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_D = 3'd1,
    INIT_N = 3'd2,
    ITER_N = 3'd3,
    ITER_D = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [1:0]       sela_q, selb_q;
  logic             la_q, lb_q, lc_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT_D;
          iter_d  = '0;
        end
      end
      INIT_D: state_d = INIT_N;
      INIT_N: state_d = ITER_N;
      ITER_N: begin
        // The last refinement skips the final D update and goes straight to DONE.
        iter_d  = iter_q + CNT_W'(1);
        state_d = (iter_d == ITERS_C) ? DONE : ITER_D;
      end
      ITER_D: state_d = ITER_N;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
      sela_q  <= 2'b00;
      selb_q  <= 2'b00;
      la_q    <= 1'b0;
      lb_q    <= 1'b0;
      lc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      sela_q  <= 2'b00;
      selb_q  <= 2'b00;
      la_q    <= 1'b0;
      lb_q    <= 1'b0;
      lc_q    <= 1'b0;
      busy_q  <= (state_d != IDLE);
      done_q  <= 1'b0;
      unique case (state_d)
        INIT_D: begin
          sela_q <= 2'b10;
          la_q   <= 1'b1;
          lb_q   <= 1'b1;
        end
        INIT_N: begin
          sela_q <= 2'b10;
          selb_q <= 2'b01;
          lc_q   <= 1'b1;
        end
        ITER_N: begin
          selb_q <= 2'b11;
          lc_q   <= 1'b1;
        end
        ITER_D: begin
          selb_q <= 2'b10;
          la_q   <= 1'b1;
          lb_q   <= 1'b1;
        end
        DONE:    done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign sel_muxa = sela_q;
  assign sel_muxb = selb_q;
  assign loada    = la_q;
  assign loadb    = lb_q;
  assign loadc    = lc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign iter     = iter_q;

`ifndef SYNTHESIS
  a_one_load:   assert property (@(posedge clk) !(loadb && loadc));
  a_loada_only: assert property (@(posedge clk) loada |-> loadb);
  a_sel_legal:  assert property (@(posedge clk) sel_muxa != 2'b11);
  a_done_prev:  assert property (@(posedge clk) disable iff (reset)
                                 done |-> ($past(state_q) == ITER_N));
`endif

endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
Control sequencer for the single-multiplier Goldschmidt FP-divide mantissa datapath (fpdiv). It accepts a start request and drives the datapath's mux selects and register load enables cycle by cycle. It runs the initial-approximation step, then ITERS N/D refinement iterations, and signals completion when the quotient mantissa is held in datapath register C. It is a pure Moore FSM plus an iteration counter and holds no datapath bits.

Parameters:
ITERS, 3, number of Goldschmidt numerator refinements; legal range 1..7 (elaboration error otherwise)
CNT_W, 3, width of the iteration counter; must satisfy 2**CNT_W > ITERS

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high; forces IDLE on the next posedge
start  input  1  begin a division; sampled only in IDLE
sel_muxa  output  2  datapath mux A select: 00=regA (K), 01=d, 10=initial approximation; 11 never driven
sel_muxb  output  2  datapath mux B select: 00=d, 01=x, 10=regB (D), 11=regC (N)
loada  output  1  load regA with the ones-complement of the product (K = 2 - D)
loadb  output  1  load regB with the product (D)
loadc  output  1  load regC with the product (N)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; quotient in regC is valid
iter  output  CNT_W  completed numerator refinements (debug and verification)

Behaviour:
- States: IDLE, INIT_D, INIT_N, ITER_N, ITER_D, DONE. Outputs decode from the registered state only (Moore) and have no combinational path from start.
- Reset: state=IDLE, iter=0. All outputs are 0 (sel_muxa=00, sel_muxb=00, loads=0, busy=0, done=0) in the cycle after the reset edge. Reset in any state, including mid-iteration, aborts the operation with no done pulse.
- IDLE: outputs 0. If start=1 at posedge, go to INIT_D and set iter=0. Otherwise stay.
- INIT_D: sel_muxa=10, sel_muxb=00, loadb=1, loada=1 (D0=IA*d, K1=~D0). Next state INIT_N.
- INIT_N: sel_muxa=10, sel_muxb=01, loadc=1 (N0=IA*x). Next state ITER_N.
- ITER_N: sel_muxa=00, sel_muxb=11, loadc=1 (N=K*N). iter increments at the posedge leaving this state. If the incremented iter equals ITERS, go to DONE; otherwise go to ITER_D.
- ITER_D: sel_muxa=00, sel_muxb=10, loadb=1, loada=1 (D=K*D, K=2-D). Next state ITER_N. The final D update is skipped because the last iteration goes ITER_N→DONE.
- DONE: done=1, busy=1, all loads 0, selects 00. Next state is IDLE unconditionally. iter holds ITERS until the next start.
- Latency: start sampled at edge 0 gives done in cycle 2*ITERS+2 (ITERS=3 → cycle 8). Back-to-back throughput is 1 op per 2*ITERS+3 cycles, since start must be seen in IDLE.
- start while busy (including in DONE) is ignored and not queued.
- At most one of loadb/loadc is high in any cycle. loada is high only with loadb. sel_muxa is never 11.
- Counter: iter saturates logically at ITERS and never wraps within an operation.
- Assertions required: the single-load and sel legality rules above; done implies the previous state was ITER_N.

Test Plan:
- Reset at power-up, start=0 for 5 cycles → outputs all 0, busy=0, iter=0 throughout.
- ITERS=3, start pulse at cycle 0 → state trace INIT_D,INIT_N,N,D,N,D,N,DONE. Per cycle: (sel_a,sel_b,la,lb,lc) = (10,00,1,1,0),(10,01,0,0,1),(00,11,0,0,1),(00,10,1,1,0),... Done=1 only in cycle 8, then IDLE, iter=3.
- ITERS=1 → INIT_D,INIT_N,ITER_N,DONE. Done in cycle 4, with no ITER_D cycle.
- start held high continuously, ITERS=3 → start ignored while busy. Second op enters INIT_D at cycle 10, with done pulses at cycles 8 and 18.
- reset asserted during the second ITER_D → IDLE next cycle, all outputs 0, no done pulse. A new start then completes normally in 8 cycles.
- Cosimulation with the fpdiv datapath, d=1.5 (0xC00000), x=1.2 → regC at done within 2^-20 of 0.8. A random run of 1000 operands meets the same error bound.
